keccak_squeeze: RTL and testbench

KECCAK_SQUEEZE -- requirements
Module: keccak_squeeze

---
 rtl/keccak_pkg.sv | 31 +++
 rtl/keccak_squeeze_if.sv | 28 ++
 rtl/squeeze_rate_buffer.sv | 42 ++++
 rtl/keccak_squeeze.sv | 110 +++++++++++
 tb/tb_keccak_squeeze.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/keccak_pkg.sv
// Keccak geometry shared by the squeeze block and the sliced state RAM.
// A slice group carries lane l of slice s at bit s*NUM_LANES + l.
package keccak_pkg;

    localparam int PARALLEL_SLICES = 16;
    localparam int NUM_SUB_ROUNDS  = 64 / PARALLEL_SLICES;
    localparam int RATE_LANES      = 17;
    localparam int NUM_LANES       = 25;
    localparam int LANE_W          = 64;
    localparam int DATA_W          = 32;
    localparam int LEN_W           = 16;
    localparam int STATE_W         = NUM_LANES * PARALLEL_SLICES;
    localparam int WORDS_PER_BLOCK = 2 * RATE_LANES;
    localparam int ADDR_W          = $clog2(NUM_SUB_ROUNDS);
    localparam int SLICE_SH        = $clog2(PARALLEL_SLICES);
    localparam int WORD_IDX_W      = $clog2(WORDS_PER_BLOCK);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        FLUSH,
        EMIT,
        PERM,
        WAIT
    } sq_state_t;

    function automatic int group_bit(input int slice, input int lane);
        return slice * NUM_LANES + lane;
    endfunction

endpackage

// File: rtl/keccak_squeeze_if.sv
// Control, state-RAM and output-stream signals of the squeeze block.
interface keccak_squeeze_if;
    import keccak_pkg::*;

    logic                  start;
    logic [LEN_W-1:0]      len;
    logic                  busy;
    logic                  hash_re;
    logic [31:0]           raddr;
    logic [STATE_W-1:0]    state_dout;
    logic                  perm_req;
    logic                  perm_done;
    logic [DATA_W-1:0]     dout;
    logic                  dout_valid;
    logic                  dout_ready;
    logic                  done;

    modport master (
        output start, len, state_dout, perm_done, dout_ready,
        input  busy, hash_re, raddr, perm_req, dout, dout_valid, done
    );

    modport slave (
        input  start, len, state_dout, perm_done, dout_ready,
        output busy, hash_re, raddr, perm_req, dout, dout_valid, done
    );

endinterface

// File: rtl/squeeze_rate_buffer.sv
// Captures the rate lanes of the state one slice group at a time and
// presents 32-bit word k of the block (lane k/2, low half first).
module squeeze_rate_buffer
    import keccak_pkg::*;
(
    input  logic                  clk,
    input  logic                  cap_en,
    input  logic [ADDR_W-1:0]     cap_addr,
    input  logic [STATE_W-1:0]    state_dout,
    input  logic [WORD_IDX_W-1:0] word_idx,
    output logic [DATA_W-1:0]     word
);

    logic [LANE_W-1:0]          lanes [RATE_LANES];
    logic [PARALLEL_SLICES-1:0] grp   [RATE_LANES];
    logic [5:0]                 base;
    logic [LANE_W-1:0]          sel_lane;
    logic                       unused_capacity;

    // Capacity lanes are never captured.
    assign unused_capacity = ^state_dout;

    for (genvar l = 0; l < RATE_LANES; l++) begin : g_lane
        for (genvar s = 0; s < PARALLEL_SLICES; s++) begin : g_slice
            assign grp[l][s] = state_dout[group_bit(s, l)];
        end
    end

    assign base = {cap_addr, {SLICE_SH{1'b0}}};

    always_ff @(posedge clk) begin
        if (cap_en) begin
            for (int l = 0; l < RATE_LANES; l++) begin
                lanes[l][base +: PARALLEL_SLICES] <= grp[l];
            end
        end
    end

    assign sel_lane = lanes[word_idx[WORD_IDX_W-1:1]];
    assign word     = word_idx[0] ? sel_lane[63:32] : sel_lane[31:0];

endmodule

// File: rtl/keccak_squeeze.sv
// Squeeze controller: loads the rate from the state RAM, streams it as
// 32-bit words and requests further permutations until len words are out.
module keccak_squeeze
    import keccak_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    keccak_squeeze_if.slave sq
);

    sq_state_t               state_q, state_d;
    logic [ADDR_W-1:0]       sub_q, sub_d;
    logic [LEN_W-1:0]        rem_q, rem_d;
    logic [WORD_IDX_W-1:0]   k_q, k_d;
    logic                    done_q, done_d;
    logic                    cap_en_p1;
    logic [ADDR_W-1:0]       cap_addr_p1;
    logic [DATA_W-1:0]       word;

    assign sq.busy       = (state_q != IDLE);
    assign sq.hash_re    = (state_q == LOAD);
    assign sq.raddr      = sq.hash_re ? 32'(sub_q) : 32'd0;
    assign sq.perm_req   = (state_q == PERM);
    assign sq.dout_valid = (state_q == EMIT);
    assign sq.dout       = sq.dout_valid ? word : '0;
    assign sq.done       = done_q;

    always_comb begin
        state_d = state_q;
        sub_d   = sub_q;
        rem_d   = rem_q;
        k_d     = k_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (sq.start) begin
                    if (sq.len != '0) begin
                        rem_d   = sq.len;
                        k_d     = '0;
                        sub_d   = '0;
                        state_d = LOAD;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            LOAD: begin
                if (sub_q == ADDR_W'(NUM_SUB_ROUNDS - 1)) begin
                    sub_d   = '0;
                    state_d = FLUSH;
                end else begin
                    sub_d = sub_q + ADDR_W'(1);
                end
            end
            FLUSH: state_d = EMIT;
            EMIT: begin
                if (sq.dout_ready) begin
                    rem_d = rem_q - LEN_W'(1);
                    if (rem_q == LEN_W'(1)) begin
                        k_d     = '0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else if (k_q == WORD_IDX_W'(WORDS_PER_BLOCK - 1)) begin
                        k_d     = '0;
                        state_d = PERM;
                    end else begin
                        k_d = k_q + WORD_IDX_W'(1);
                    end
                end
            end
            // A perm_done arriving alongside perm_req is taken here.
            PERM: state_d = sq.perm_done ? LOAD : WAIT;
            WAIT: if (sq.perm_done) state_d = LOAD;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            sub_q     <= '0;
            rem_q     <= '0;
            k_q       <= '0;
            done_q    <= 1'b0;
            cap_en_p1 <= 1'b0;
        end else begin
            state_q   <= state_d;
            sub_q     <= sub_d;
            rem_q     <= rem_d;
            k_q       <= k_d;
            done_q    <= done_d;
            cap_en_p1 <= sq.hash_re;
        end
    end

    // p1: RAM data for the previous cycle's raddr is on state_dout.
    always_ff @(posedge clk) begin
        cap_addr_p1 <= sub_q;
    end

    squeeze_rate_buffer u_rate_buffer (
        .clk        (clk),
        .cap_en     (cap_en_p1),
        .cap_addr   (cap_addr_p1),
        .state_dout (sq.state_dout),
        .word_idx   (k_q),
        .word       (word)
    );

endmodule

// File: tb/tb_keccak_squeeze.sv
// Bench for keccak_squeeze: sliced state-RAM and permutation responders
// plus a word-stream reference built directly from lane values.
`timescale 1ns/1ps
module tb_keccak_squeeze;
    import keccak_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    keccak_squeeze_if sq();

    keccak_squeeze dut (
        .clk (clk),
        .rst (rst),
        .sq  (sq)
    );

    int checks = 0;
    int errors = 0;

    logic [63:0] states [4][NUM_LANES];
    int          cur_blk = 0;
    logic [31:0] got [$];

    typedef struct {
        int len;
        int rmode;      // 0: always ready, 1: 1,0,0 repeating, 2: random
        int plat;       // perm_done delay after perm_req, 0 = same cycle
        bit noise;      // extra start / perm_done pulses during EMIT
        int exp_xfers;
        int exp_perms;
    } case_t;

    case_t cases [9];

    function automatic int clamp_blk(input int b);
        return (b > 3) ? 3 : ((b < 0) ? 0 : b);
    endfunction

    function automatic logic [STATE_W-1:0] pack_group(input int blk, input int a);
        logic [STATE_W-1:0] g;
        g = '0;
        for (int s = 0; s < PARALLEL_SLICES; s++)
            for (int l = 0; l < NUM_LANES; l++)
                g[s*NUM_LANES + l] = states[clamp_blk(blk)][l][(a*PARALLEL_SLICES + s) % 64];
        return g;
    endfunction

    function automatic logic [STATE_W-1:0] noise_group();
        logic [STATE_W-1:0] g;
        for (int i = 0; i < STATE_W; i++) g[i] = 1'($urandom);
        return g;
    endfunction

    // Output word w: block w/34, lane (w%34)/2, low half first.
    function automatic logic [31:0] exp_word(input int w);
        int          blk;
        int          k;
        logic [63:0] lane;
        blk  = clamp_blk(w / WORDS_PER_BLOCK);
        k    = w % WORDS_PER_BLOCK;
        lane = states[blk][k / 2];
        return 32'(lane >> (32 * (k % 2)));
    endfunction

    always @(posedge clk) begin
        if (sq.hash_re) sq.state_dout <= pack_group(cur_blk, int'(sq.raddr));
        else            sq.state_dout <= noise_group();
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic new_states();
        for (int b = 0; b < 4; b++)
            for (int l = 0; l < NUM_LANES; l++)
                states[b][l] = {$urandom, $urandom};
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"},       sq.busy, 0);
        chk({tag, "_hash_re"},    sq.hash_re, 0);
        chk({tag, "_raddr"},      sq.raddr, 0);
        chk({tag, "_perm_req"},   sq.perm_req, 0);
        chk({tag, "_dout_valid"}, sq.dout_valid, 0);
        chk({tag, "_dout"},       sq.dout, 0);
        chk({tag, "_done"},       sq.done, 0);
    endtask

    task automatic run_case(input int len_i, input int rmode, input int plat,
                            input bit noise, input int exp_xfers, input int exp_perms);
        int          nxfer, nperm, ldcnt, hre_total, first_valid, last_xfer, pcnt, rcnt;
        bit          prev_hold, seen_done, prev_perm, r;
        logic [31:0] prev_dout;
        got.delete();
        cur_blk = 0;
        nxfer = 0; nperm = 0; ldcnt = 0; hre_total = 0; first_valid = -1;
        last_xfer = 0; pcnt = -1; rcnt = 0;
        prev_hold = 0; seen_done = 0; prev_perm = 0; prev_dout = '0;
        @(negedge clk);
        sq.start = 1'b1; sq.len = 16'(len_i); sq.perm_done = 1'b0; sq.dout_ready = 1'b0;
        for (int cyc = 1; cyc <= 3000 && !seen_done; cyc++) begin
            @(negedge clk);
            sq.start = 1'b0;
            sq.perm_done = 1'b0;
            if (cyc == 1) chk("busy_after_start", sq.busy, len_i > 0);

            if (sq.hash_re) begin
                chk("raddr_seq", sq.raddr, ldcnt);
                ldcnt++;
                hre_total++;
            end else begin
                if (ldcnt != 0) chk("load_length", ldcnt, NUM_SUB_ROUNDS);
                ldcnt = 0;
                chk("raddr_zero", sq.raddr, 0);
            end

            if (sq.perm_req) begin
                chk("perm_req_pulse", prev_perm, 0);
                chk("perm_at_block_end", nxfer, (nperm + 1) * WORDS_PER_BLOCK);
                nperm++;
                pcnt = plat;
            end
            prev_perm = sq.perm_req;
            if (pcnt == 0) begin
                sq.perm_done = 1'b1;
                cur_blk++;
                pcnt = -1;
            end else if (pcnt > 0) begin
                pcnt--;
            end

            if (sq.dout_valid) begin
                if (first_valid < 0) begin
                    first_valid = cyc;
                    chk("first_valid_latency", cyc, NUM_SUB_ROUNDS + 2);
                end
                chk("dout_word", sq.dout, exp_word(nxfer));
                if (prev_hold) chk("dout_held", sq.dout, prev_dout);
                case (rmode)
                    0:       r = 1'b1;
                    1:       r = (rcnt % 3 == 0);
                    default: r = 1'($urandom_range(0, 1));
                endcase
                rcnt++;
                sq.dout_ready = r;
                if (noise) begin
                    sq.start = 1'($urandom_range(0, 1));
                    sq.len   = 16'd7;
                    if (pcnt < 0) sq.perm_done = 1'($urandom_range(0, 1));
                end
                if (r) begin
                    got.push_back(sq.dout);
                    nxfer++;
                    last_xfer = cyc;
                end
            end else begin
                if (prev_hold) chk("valid_held", sq.dout_valid, 1);
                sq.dout_ready = 1'($urandom_range(0, 1));
            end
            prev_hold = sq.dout_valid && !sq.dout_ready;
            prev_dout = sq.dout;

            if (sq.done) begin
                seen_done = 1'b1;
                chk("done_timing", cyc, last_xfer + 1);
                chk("done_valid_low", sq.dout_valid, 0);
                chk("done_busy_low", sq.busy, 0);
            end
        end
        chk("done_seen", seen_done, 1);
        chk("valid_seen", first_valid >= 0, len_i > 0);
        chk("xfer_count", nxfer, exp_xfers);
        chk("perm_count", nperm, exp_perms);
        chk("load_cycles", hre_total, (len_i > 0) ? NUM_SUB_ROUNDS * (exp_perms + 1) : 0);
        sq.dout_ready = 1'b0;
        sq.start = 1'b0;
        sq.perm_done = 1'b0;
        @(negedge clk);
        chk("done_one_cycle", sq.done, 0);
        chk("idle_valid_low", sq.dout_valid, 0);
    endtask

    initial begin
        logic [31:0] fixed_exp [4];
        int          emit;

        cases[0] = '{len: 4,  rmode: 0, plat: 0, noise: 0, exp_xfers: 4,  exp_perms: 0};
        cases[1] = '{len: 35, rmode: 0, plat: 3, noise: 0, exp_xfers: 35, exp_perms: 1};
        cases[2] = '{len: 3,  rmode: 1, plat: 0, noise: 0, exp_xfers: 3,  exp_perms: 0};
        cases[3] = '{len: 0,  rmode: 0, plat: 0, noise: 0, exp_xfers: 0,  exp_perms: 0};
        cases[4] = '{len: 1,  rmode: 2, plat: 0, noise: 0, exp_xfers: 1,  exp_perms: 0};
        cases[5] = '{len: 34, rmode: 0, plat: 0, noise: 0, exp_xfers: 34, exp_perms: 0};
        cases[6] = '{len: 69, rmode: 2, plat: 0, noise: 0, exp_xfers: 69, exp_perms: 2};
        cases[7] = '{len: 40, rmode: 0, plat: 5, noise: 1, exp_xfers: 40, exp_perms: 1};
        cases[8] = '{len: 20, rmode: 2, plat: 2, noise: 1, exp_xfers: 20, exp_perms: 0};

        fixed_exp[0] = 32'h89ABCDEF;
        fixed_exp[1] = 32'h01234567;
        fixed_exp[2] = 32'h76543210;
        fixed_exp[3] = 32'hFEDCBA98;

        sq.start = 1'b0; sq.len = '0; sq.perm_done = 1'b0; sq.dout_ready = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b0;

        // Known lane values give fixed expected words.
        new_states();
        states[0][0] = 64'h0123456789ABCDEF;
        states[0][1] = 64'hFEDCBA9876543210;
        run_case(4, 0, 0, 1'b0, 4, 0);
        for (int i = 0; i < 4; i++)
            chk("fixed_word", (i < got.size()) ? got[i] : 32'hDEAD_0000, fixed_exp[i]);

        for (int t = 0; t < 9; t++) begin
            new_states();
            run_case(cases[t].len, cases[t].rmode, cases[t].plat, cases[t].noise,
                     cases[t].exp_xfers, cases[t].exp_perms);
        end

        // Reset during the second EMIT cycle aborts without done.
        new_states();
        cur_blk = 0;
        @(negedge clk);
        sq.start = 1'b1; sq.len = 16'd5; sq.dout_ready = 1'b1;
        emit = 0;
        for (int c = 1; c <= 40 && emit < 2; c++) begin
            @(negedge clk);
            sq.start = 1'b0;
            if (sq.dout_valid) begin
                if (emit == 0) chk("abort_first_word", sq.dout, exp_word(0));
                emit++;
            end
        end
        chk("abort_reached_emit2", emit, 2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sq.dout_ready = 1'b0;
        chk_all_zero("abort");
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("abort_no_done", sq.done, 0);
        end
        new_states();
        run_case(2, 0, 0, 1'b0, 2, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
